axicb_mst_switch_wr: RTL and testbench

AXICB_MST_SWITCH_WR -- requirements
Module: axicb_mst_switch_wr

---
 rtl/axicb_pkg.sv | 27 ++
 rtl/axicb_scfifo.sv | 79 +++++++
 rtl/axicb_mst_switch_wr.sv | 157 +++++++++++++++
 tb/tb_axicb_mst_switch_wr.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axicb_pkg.sv
`default_nettype none
// ============================================================================
// axicb_pkg : shared types and helpers for the AXI crossbar switch slices
// Rev 1.0
// ============================================================================
package axicb_pkg;

    localparam int MST_NB = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // First requester found when scanning upward from ptr, wrapping at MST_NB.
    function automatic logic [1:0] rr_pick(input logic [MST_NB-1:0] req,
                                           input logic [1:0]        ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int i = MST_NB - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/axicb_scfifo.sv
`default_nettype none
// ============================================================================
// axicb_scfifo : single-clock FIFO, optional pass-through when empty
// Rev 1.0
// ============================================================================
module axicb_scfifo
    import axicb_pkg::*;
#(
    parameter int PASS_THRU  = 0,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 2
)(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  pop,
    output logic                  empty
);

    localparam int                c_depth      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_full_count = (ADDR_WIDTH + 1)'(c_depth);

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_none;
    logic                  w_bypass;
    logic                  w_store;
    logic                  w_fetch;

    assign w_none = (r_count == '0);
    assign full   = (r_count == c_full_count);

    if (PASS_THRU != 0) begin : g_pass_thru
        assign w_bypass = w_none & push & pop;
        assign empty    = w_none & ~push;
        assign data_out = w_none ? data_in : r_mem[r_rd_ptr];
    end else begin : g_registered
        assign w_bypass = 1'b0;
        assign empty    = w_none;
        assign data_out = r_mem[r_rd_ptr];
    end

    // A full FIFO still accepts a write when the same cycle frees a slot.
    assign w_store = push & (~full | pop) & ~w_bypass;
    assign w_fetch = pop & ~w_none;

    always_ff @(posedge aclk) begin
        if (w_store) r_mem[r_wr_ptr] <= data_in;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (srst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            if (w_fetch) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            case ({w_store, w_fetch})
                2'b10:   r_count <= r_count + (ADDR_WIDTH + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_WIDTH + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/axicb_mst_switch_wr.sv
`default_nettype none
// ============================================================================
// axicb_mst_switch_wr : write-channel switch, four masters onto one slave
// Rev 1.0
// ============================================================================
module axicb_mst_switch_wr
    import axicb_pkg::*;
#(
    parameter int                  AXI_ADDR_W    = 8,
    parameter int                  AXI_ID_W      = 8,
    parameter int                  MST_NB        = 4,
    parameter logic [AXI_ID_W-1:0] MST_ID_MATCH  = 'hC0,
    parameter logic [AXI_ID_W-1:0] MST0_ID_MASK  = 'h00,
    parameter logic [AXI_ID_W-1:0] MST1_ID_MASK  = 'h40,
    parameter logic [AXI_ID_W-1:0] MST2_ID_MASK  = 'h80,
    parameter logic [AXI_ID_W-1:0] MST3_ID_MASK  = 'hC0,
    parameter int                  WFIFO_DEPTH_W = 3,
    parameter int                  AWCH_W        = 8,
    parameter int                  WCH_W         = 8,
    parameter int                  BCH_W         = 10
)(
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     srst,
    input  logic [MST_NB-1:0]        i_awvalid,
    output logic [MST_NB-1:0]        i_awready,
    input  logic [MST_NB*AWCH_W-1:0] i_awch,
    input  logic [MST_NB-1:0]        i_wvalid,
    output logic [MST_NB-1:0]        i_wready,
    input  logic [MST_NB-1:0]        i_wlast,
    input  logic [MST_NB*WCH_W-1:0]  i_wch,
    output logic [MST_NB-1:0]        i_bvalid,
    input  logic [MST_NB-1:0]        i_bready,
    output logic [BCH_W-1:0]         i_bch,
    output logic                     o_awvalid,
    input  logic                     o_awready,
    output logic [AWCH_W-1:0]        o_awch,
    output logic                     o_wvalid,
    input  logic                     o_wready,
    output logic                     o_wlast,
    output logic [WCH_W-1:0]         o_wch,
    input  logic                     o_bvalid,
    output logic                     o_bready,
    input  logic [BCH_W-1:0]         o_bch
);

    // The address travels opaquely inside the AW payload.
    localparam int c_addr_w_unused = AXI_ADDR_W;

    localparam logic [AXI_ID_W-1:0] c_id_mask [4] = '{MST0_ID_MASK, MST1_ID_MASK,
                                                      MST2_ID_MASK, MST3_ID_MASK};

    arb_state_t        r_state;
    logic [1:0]        r_grant;
    logic [1:0]        r_ptr;
    logic              w_granted;
    logic              w_full;
    logic              w_empty;
    logic [1:0]        w_whead;
    logic              w_aw_hs;
    logic              w_w_pop;
    logic [MST_NB-1:0] w_bmatch;
    logic [AXI_ID_W-1:0] w_bid;

    // ------------------------------------------------------------ AW arbiter
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
            r_grant <= 2'd0;
            r_ptr   <= 2'd0;
        end else if (srst) begin
            r_state <= IDLE;
            r_grant <= 2'd0;
            r_ptr   <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|i_awvalid) begin
                        r_grant <= rr_pick(i_awvalid, r_ptr);
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_aw_hs) begin
                        r_ptr   <= r_grant + 2'd1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_granted = (r_state == GRANT);
    assign o_awvalid = w_granted & i_awvalid[r_grant] & ~w_full;
    assign o_awch    = i_awch[r_grant*AWCH_W +: AWCH_W];
    assign w_aw_hs   = o_awvalid & o_awready;

    always_comb begin
        i_awready = '0;
        if (w_granted && !w_full) i_awready[r_grant] = o_awready;
    end

    // ------------------------------------------------------------ W routing
    // Each granted AW queues its master index; the head owns the W channel.
    axicb_scfifo #(
        .PASS_THRU  (0),
        .ADDR_WIDTH (WFIFO_DEPTH_W),
        .DATA_WIDTH (2)
    ) u_wroute (
        .aclk     (aclk),
        .aresetn  (~areset),
        .srst     (srst),
        .flush    (1'b0),
        .data_in  (r_grant),
        .push     (w_aw_hs),
        .full     (w_full),
        .data_out (w_whead),
        .pop      (w_w_pop),
        .empty    (w_empty)
    );

    assign o_wvalid = ~w_empty & i_wvalid[w_whead];
    assign o_wlast  = ~w_empty & i_wlast[w_whead];
    assign o_wch    = i_wch[w_whead*WCH_W +: WCH_W];
    assign w_w_pop  = o_wvalid & o_wready & o_wlast;

    always_comb begin
        i_wready = '0;
        if (!w_empty) i_wready[w_whead] = o_wready;
    end

    // ------------------------------------------------------------ B routing
    assign w_bid = o_bch[0 +: AXI_ID_W];
    assign i_bch = o_bch;

    for (genvar k = 0; k < MST_NB; k++) begin : g_bmatch
        assign w_bmatch[k] = ((w_bid & MST_ID_MATCH) == c_id_mask[k]);
    end

    // Unclaimed responses are swallowed so the slave never stalls on them.
    always_comb begin
        logic w_bhit;
        w_bhit   = 1'b0;
        i_bvalid = '0;
        o_bready = 1'b1;
        for (int k = 0; k < MST_NB; k++) begin
            if (w_bmatch[k] && !w_bhit) begin
                i_bvalid[k] = o_bvalid;
                o_bready    = i_bready[k];
                w_bhit      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axicb_mst_switch_wr.sv
`default_nettype none
// ============================================================================
// tb_axicb_mst_switch_wr : self-checking bench, directed cases plus random
// Rev 1.0
// ============================================================================
module tb_axicb_mst_switch_wr;

    localparam int DEPTH_W = 1;
    localparam int DEPTH   = 2 ** DEPTH_W;
    localparam logic [7:0] ID_MATCH = 8'hC0;
    localparam logic [7:0] MASKS [4] = '{8'h00, 8'h40, 8'h80, 8'hC4};

    logic        aclk   = 1'b0;
    logic        areset = 1'b1;
    logic        srst   = 1'b0;
    logic [3:0]  i_awvalid, i_awready, i_wvalid, i_wready, i_wlast, i_bvalid, i_bready;
    logic [31:0] i_awch, i_wch;
    logic [9:0]  i_bch, o_bch;
    logic        o_awvalid, o_awready, o_wvalid, o_wready, o_wlast, o_bvalid, o_bready;
    logic [7:0]  o_awch, o_wch;

    int n_vec = 0;
    int n_err = 0;

    axicb_mst_switch_wr #(
        .WFIFO_DEPTH_W (DEPTH_W),
        .MST3_ID_MASK  (8'hC4)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .srst      (srst),
        .i_awvalid (i_awvalid),
        .i_awready (i_awready),
        .i_awch    (i_awch),
        .i_wvalid  (i_wvalid),
        .i_wready  (i_wready),
        .i_wlast   (i_wlast),
        .i_wch     (i_wch),
        .i_bvalid  (i_bvalid),
        .i_bready  (i_bready),
        .i_bch     (i_bch),
        .o_awvalid (o_awvalid),
        .o_awready (o_awready),
        .o_awch    (o_awch),
        .o_wvalid  (o_wvalid),
        .o_wready  (o_wready),
        .o_wlast   (o_wlast),
        .o_wch     (o_wch),
        .o_bvalid  (o_bvalid),
        .o_bready  (o_bready),
        .o_bch     (o_bch)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    int m_g = -1;      // master holding the AW grant, -1 when none
    int m_ptr = 0;     // round-robin start point
    int m_q[$];        // masters whose AW was accepted, oldest first

    function automatic int pick_next(input logic [3:0] req, input int ptr);
        for (int i = 0; i < 4; i++)
            if (req[(ptr + i) % 4]) return (ptr + i) % 4;
        return -1;
    endfunction

    function automatic int b_target(input logic [7:0] id);
        for (int k = 0; k < 4; k++)
            if ((id & ID_MATCH) == MASKS[k]) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_g   = -1;
        m_ptr = 0;
        m_q.delete();
    endtask

    task automatic model_step();
        bit aw_hs, w_pop;
        aw_hs = (m_g >= 0) && i_awvalid[m_g] && (m_q.size() < DEPTH) && o_awready;
        w_pop = (m_q.size() > 0) && i_wvalid[m_q[0]] && o_wready && i_wlast[m_q[0]];
        if (w_pop) void'(m_q.pop_front());
        if (aw_hs) begin
            m_q.push_back(m_g);
            m_ptr = (m_g + 1) % 4;
            m_g   = -1;
        end else if (m_g < 0) begin
            m_g = pick_next(i_awvalid, m_ptr);
        end
    endtask

    task automatic compare_all();
        logic       exp_awv, exp_wv, exp_br;
        logic [3:0] exp_awr, exp_wr, exp_bv;
        int         h, t;
        bit         full;
        full    = (m_q.size() == DEPTH);
        exp_awv = 1'b0;
        exp_awr = 4'b0;
        if (m_g >= 0 && !full) begin
            exp_awv        = i_awvalid[m_g];
            exp_awr[m_g]   = o_awready;
        end
        chk("o_awvalid", 32'(o_awvalid), 32'(exp_awv));
        chk("i_awready", 32'(i_awready), 32'(exp_awr));
        if (m_g >= 0) chk("o_awch", 32'(o_awch), 32'(i_awch[m_g*8 +: 8]));
        exp_wv = 1'b0;
        exp_wr = 4'b0;
        h      = 0;
        if (m_q.size() > 0) begin
            h          = m_q[0];
            exp_wv     = i_wvalid[h];
            exp_wr[h]  = o_wready;
        end
        chk("o_wvalid", 32'(o_wvalid), 32'(exp_wv));
        chk("i_wready", 32'(i_wready), 32'(exp_wr));
        if (exp_wv) begin
            chk("o_wch", 32'(o_wch), 32'(i_wch[h*8 +: 8]));
            chk("o_wlast", 32'(o_wlast), 32'(i_wlast[h]));
        end
        t      = b_target(o_bch[7:0]);
        exp_bv = (t >= 0) ? (4'(o_bvalid) << t) : 4'b0;
        exp_br = (t >= 0) ? i_bready[t] : 1'b1;
        chk("i_bvalid", 32'(i_bvalid), 32'(exp_bv));
        chk("o_bready", 32'(o_bready), 32'(exp_br));
        chk("i_bch", 32'(i_bch), 32'(o_bch));
    endtask

    // Model advances on rising edges (and async reset); DUT compared on falling edges.
    logic last_clk = 1'b0;
    initial begin
        forever begin
            @(posedge aclk or negedge aclk or posedge areset);
            if (areset) model_reset();
            if (aclk !== last_clk) begin
                last_clk = aclk;
                if (!aclk) compare_all();
                else if (areset || srst) model_reset();
                else model_step();
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge aclk);
    endtask

    task automatic idle_inputs();
        i_awvalid = 4'b0; i_awch = 32'h0; i_wvalid = 4'b0; i_wlast = 4'b0; i_wch = 32'h0;
        i_bready  = 4'b0; o_awready = 1'b0; o_wready = 1'b0; o_bvalid = 1'b0; o_bch = 10'h0;
    endtask

    logic [3:0] exp_rdy  [8];
    logic       exp_stl  [11];
    logic [9:0] bch_v    [4];
    logic [3:0] brdy_v   [4];
    logic [3:0] exp_bv_v [4];
    logic       exp_br_v [4];

    initial begin
        exp_rdy  = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8};
        exp_stl  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bch_v    = '{10'h285, 10'h285, 10'h005, 10'h0C5};
        brdy_v   = '{4'b0100, 4'b1011, 4'b0000, 4'b0000};
        exp_bv_v = '{4'b0100, 4'b0100, 4'b0001, 4'b0000};
        exp_br_v = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state with busy inputs
        idle_inputs();
        i_awvalid = 4'hF; i_wvalid = 4'hF; o_awready = 1'b1; o_wready = 1'b1;
        cyc();
        at_neg();
        chk("rst_awvalid", 32'(o_awvalid), 32'd0);
        chk("rst_awready", 32'(i_awready), 32'd0);
        chk("rst_wvalid",  32'(o_wvalid),  32'd0);
        chk("rst_wready",  32'(i_wready),  32'd0);
        cyc();
        areset = 1'b0;
        idle_inputs();
        cyc();

        // Four simultaneous requesters served 0,1,2,3 every other cycle
        i_awvalid = 4'hF; o_awready = 1'b1; i_wvalid = 4'hF; i_wlast = 4'hF; o_wready = 1'b1;
        i_awch = 32'hD3C2B1A0;
        for (int c = 0; c < 8; c++) begin
            at_neg();
            chk("rr_order",   32'(i_awready), 32'(exp_rdy[c]));
            chk("rr_awvalid", 32'(o_awvalid), 32'(c % 2));
            cyc();
        end
        i_awvalid = 4'b0;
        cyc();
        cyc();

        // Master 2: AW then a 4-beat burst
        idle_inputs();
        o_awready = 1'b1; o_wready = 1'b1; i_wvalid = 4'hF; i_awvalid = 4'b0100;
        for (int c = 0; c < 7; c++) begin
            for (int k = 0; k < 4; k++) i_wch[k*8 +: 8] = {4'(k), 4'(c)};
            i_wlast = (c == 5) ? 4'b0100 : 4'b0000;
            if (c == 2) i_awvalid = 4'b0;
            at_neg();
            chk("burst_wvalid", 32'(o_wvalid), 32'(c >= 2 && c <= 5));
            chk("burst_wready", 32'(i_wready), (c >= 2 && c <= 5) ? 32'h4 : 32'h0);
            if (c >= 2 && c <= 5) chk("burst_wch", 32'(o_wch), 32'({4'h2, 4'(c)}));
            cyc();
        end
        idle_inputs();
        cyc();

        // Two-entry route FIFO fills; third AW waits for a wlast handshake
        o_awready = 1'b1; i_awvalid = 4'b0011;
        for (int c = 0; c < 11; c++) begin
            if (c == 9) begin
                i_wvalid = 4'b0001; i_wlast = 4'b0001; o_wready = 1'b1;
            end else begin
                i_wvalid = 4'b0; i_wlast = 4'b0;
            end
            at_neg();
            chk("full_stall", 32'(o_awvalid), 32'(exp_stl[c]));
            cyc();
        end

        // Async reset while master 1 holds a stalled grant and FIFO is full
        i_awvalid = 4'b0010; i_wvalid = 4'hF; i_wlast = 4'b0; o_wready = 1'b1;
        cyc();
        at_neg();
        chk("pre_rst_stall", 32'(o_awvalid), 32'd0);
        chk("pre_rst_wflow", 32'(o_wvalid),  32'd1);
        #1 areset = 1'b1;
        #1;
        chk("arst_awvalid", 32'(o_awvalid), 32'd0);
        chk("arst_awready", 32'(i_awready), 32'd0);
        chk("arst_wvalid",  32'(o_wvalid),  32'd0);
        chk("arst_wready",  32'(i_wready),  32'd0);
        #1 areset = 1'b0;
        i_awvalid = 4'hF;
        cyc();
        at_neg();
        chk("arst_ptr_zero", 32'(i_awready), 32'h1);
        cyc();
        i_awvalid = 4'b0; i_wvalid = 4'b0;
        srst = 1'b1;
        cyc();
        srst = 1'b0;
        cyc();

        // W from master 3 shows up a cycle ahead of its AW
        idle_inputs();
        o_awready = 1'b1; o_wready = 1'b1; i_wch = 32'h3C5A5A5A;
        for (int c = 0; c < 5; c++) begin
            i_wvalid  = (c <= 3) ? 4'b1000 : 4'b0000;
            i_wlast   = i_wvalid;
            i_awvalid = (c == 1 || c == 2) ? 4'b1000 : 4'b0000;
            at_neg();
            chk("early_w_valid", 32'(o_wvalid), 32'(c == 3));
            chk("early_w_ready", 32'(i_wready), (c == 3) ? 32'h8 : 32'h0);
            if (c == 3) chk("early_w_data", 32'(o_wch), 32'h3C);
            cyc();
        end

        // B routing by ID tag, including an unclaimed ID
        idle_inputs();
        for (int n = 0; n < 4; n++) begin
            o_bvalid = 1'b1;
            o_bch    = bch_v[n];
            i_bready = brdy_v[n];
            at_neg();
            chk("b_route", 32'(i_bvalid), 32'(exp_bv_v[n]));
            chk("b_ready", 32'(o_bready), 32'(exp_br_v[n]));
            if (n == 0) chk("b_payload", 32'(i_bch), 32'h285);
            cyc();
        end

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            i_awvalid = 4'($urandom);
            i_awch    = $urandom;
            i_wvalid  = 4'($urandom);
            i_wlast   = 4'($urandom);
            i_wch     = $urandom;
            i_bready  = 4'($urandom);
            o_awready = ($urandom_range(0, 3) != 0);
            o_wready  = 1'($urandom_range(0, 1));
            o_bvalid  = 1'($urandom_range(0, 1));
            o_bch     = 10'($urandom);
            srst      = ($urandom_range(0, 199) == 0);
            cyc();
        end
        srst = 1'b0;
        idle_inputs();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
